addr_fifo_buf: RTL and testbench
================================

Name: addr_fifo_buf

Overview:
- Synchronous address FIFO directly downstream of the driver control path.
- Accepts test-vector addresses on addr_fifo_din/addr_fifo_wr and presents them to the vector fetch stage via addr_fifo_rd/addr_fifo_dout.
- Produces the full, empty, almost-full, overrun/underrun and occupancy status that the driver control and monitor consume.
- Single clock domain, circular buffer in inferred RAM with registered read data.

Parameters:
- DATA_WIDTH, 32, width of each stored address word.
- DEPTH_LOG2, 9, log2 of the entry count (512 entries). Legal range is 2..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr_fifo_din  in  DATA_WIDTH  write data.
- addr_fifo_wr  in  1  write strobe, one word per cycle.
- addr_fifo_rd  in  1  read strobe, one word per cycle.
- addr_fifo_dout  out  DATA_WIDTH  registered read data.
- addr_fifo_dout_val  out  1  pulses the cycle after an accepted read.
- addr_fifo_full  out  1  occupancy equals 2^DEPTH_LOG2.
- addr_fifo_empty  out  1  occupancy equals 0.
- addr_fifo_almost_full  out  1  occupancy has reached the threshold.
- addr_fifo_threshold  in  16  almost-full level; 0 disables the flag.
- addr_fifo_overrun  out  1  sticky: a write was dropped.
- addr_fifo_underrun  out  1  sticky: a read was rejected.
- clr_flags  in  1  synchronous clear of the sticky flags.
- words_in_addr_fifo  out  16  current occupancy, zero-extended.

Behaviour:
- Reset (reset=0, asynchronous) forces the following state:
  - wr_ptr, rd_ptr and count = 0.
  - addr_fifo_empty = 1.
  - addr_fifo_full = 0, addr_fifo_almost_full = 0.
  - addr_fifo_overrun = 0, addr_fifo_underrun = 0.
  - addr_fifo_dout = 0, addr_fifo_dout_val = 0.
  - words_in_addr_fifo = 0.
  - RAM contents are not reset.
- Reset asserted mid-operation discards all stored words; after release the FIFO is empty.
- Pointers are DEPTH_LOG2 bits wide and wrap naturally from 2^DEPTH_LOG2-1 to 0. Count is DEPTH_LOG2+1 bits.
- Write acceptance: the write is accepted when addr_fifo_wr=1 and (not full, or an accepted read occurs in the same cycle).
  - An accepted write stores din at wr_ptr and increments wr_ptr.
  - A rejected write sets addr_fifo_overrun; the stored data is unchanged.
- Read acceptance: the read is accepted when addr_fifo_rd=1 and not empty, judged on the pre-cycle count.
  - An accepted read registers mem[rd_ptr] into addr_fifo_dout, increments rd_ptr, and sets addr_fifo_dout_val=1 on the next cycle. Read latency is 1 cycle.
  - A rejected read sets addr_fifo_underrun and leaves addr_fifo_dout holding its previous value.
- Simultaneous write and read:
  - When full, both are accepted; count stays at max.
  - When empty, the write is accepted and the read is rejected (no fall-through); underrun is set and count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- Count update: count += accepted_wr - accepted_rd.
- All status flags are registered and reflect the post-update count in the same edge:
  - full = (count == 2^DEPTH_LOG2).
  - empty = (count == 0).
  - almost_full = (threshold != 0) && (count >= threshold). A threshold above the depth never asserts the flag.
- words_in_addr_fifo = count zero-extended to 16 bits.
- Sticky flags:
  - clr_flags=1 clears overrun and underrun.
  - If clr_flags and a new violation occur in the same cycle, the set wins and the flag stays 1.

Optional Feature:
- Macro: ADDR_FIFO_HWM_EN.
- When defined:
  - Adds output addr_fifo_hwm [15:0], a high-water mark of count.
  - Reset value is 0.
  - Each cycle it updates to max(hwm, post-update count).
  - clr_flags also clears it to the current count.
- When undefined: the port and register are absent and all other behaviour is identical.

Test Plan:
- Reset, then write 0x1000..0x1003 on 4 consecutive cycles.
  - Count goes 1,2,3,4; empty deasserts after the first edge.
  - Four reads return 0x1000..0x1003 with dout_val one cycle after each rd; empty=1 after the last.
- DEPTH_LOG2=2: write 4 words, then write 0xDEAD.
  - full=1 and count=4; overrun=1; 0xDEAD is never read back.
  - clr_flags clears overrun.
- Read while empty.
  - underrun=1, dout unchanged, dout_val=0.
  - Simultaneous wr+rd on empty: count=1 and underrun=1.
- threshold=3: write 3 words.
  - almost_full asserts on the 3rd write edge; one read deasserts it.
  - threshold=0: 4 writes leave almost_full=0.
- Full with simultaneous wr+rd for 10 cycles.
  - Count stays at 4, no overrun; data order preserved across pointer wrap.
- Assert reset low mid-stream with 3 words stored.
  - All outputs take their reset values immediately (asynchronously), count=0.
  - With ADDR_FIFO_HWM_EN: hwm shows 3 before the reset and 0 after it.

Source files
------------

// File: rtl/addr_fifo_buf.sv
// Address FIFO between the driver control path and the vector fetch stage.
// Optional high-water-mark output enabled by defining ADDR_FIFO_HWM_EN.
module addr_fifo_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] addr_fifo_din,
  input  logic                  addr_fifo_wr,
  input  logic                  addr_fifo_rd,
  output logic [DATA_WIDTH-1:0] addr_fifo_dout,
  output logic                  addr_fifo_dout_val,
  output logic                  addr_fifo_full,
  output logic                  addr_fifo_empty,
  output logic                  addr_fifo_almost_full,
  input  logic [15:0]           addr_fifo_threshold,
  output logic                  addr_fifo_overrun,
  output logic                  addr_fifo_underrun,
  input  logic                  clr_flags,
  output logic [15:0]           words_in_addr_fifo
`ifdef ADDR_FIFO_HWM_EN
  ,
  output logic [15:0]           addr_fifo_hwm
`endif
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_val;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_overrun;
  logic                  r_underrun;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [CW-1:0]         w_count_next;

  // A read is judged on the pre-cycle count, so there is no fall-through on empty;
  // a write into a full FIFO is allowed only when a read frees a slot in the same cycle.
  assign w_rd_acc     = addr_fifo_rd && !r_empty;
  assign w_wr_acc     = addr_fifo_wr && (!r_full || w_rd_acc);
  assign w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= addr_fifo_din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_dout        <= '0;
      r_dout_val    <= 1'b0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almost_full <= 1'b0;
      r_overrun     <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_dout_val    <= w_rd_acc;
      r_count       <= w_count_next;
      r_full        <= (w_count_next == DEPTH);
      r_empty       <= (w_count_next == '0);
      r_almost_full <= (addr_fifo_threshold != 16'd0) &&
                       (16'(w_count_next) >= addr_fifo_threshold);
      // A new violation in the same cycle as clr_flags keeps the flag set.
      r_overrun     <= (addr_fifo_wr && !w_wr_acc) || (r_overrun && !clr_flags);
      r_underrun    <= (addr_fifo_rd && !w_rd_acc) || (r_underrun && !clr_flags);
    end
  end

`ifdef ADDR_FIFO_HWM_EN
  logic [15:0] r_hwm;
  logic [15:0] w_hwm_next;

  always_comb begin
    w_hwm_next = r_hwm;
    if (clr_flags)                        w_hwm_next = 16'(w_count_next);
    else if (16'(w_count_next) > r_hwm)   w_hwm_next = 16'(w_count_next);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_hwm <= '0;
    else        r_hwm <= w_hwm_next;
  end

  assign addr_fifo_hwm = r_hwm;
`endif

  assign addr_fifo_dout        = r_dout;
  assign addr_fifo_dout_val    = r_dout_val;
  assign addr_fifo_full        = r_full;
  assign addr_fifo_empty       = r_empty;
  assign addr_fifo_almost_full = r_almost_full;
  assign addr_fifo_overrun     = r_overrun;
  assign addr_fifo_underrun    = r_underrun;
  assign words_in_addr_fifo    = 16'(r_count);

endmodule

// File: tb/tb_addr_fifo_buf.sv
// Directed bench for addr_fifo_buf (4-entry build) with a queue-based scoreboard;
// the high-water-mark checks follow ADDR_FIFO_HWM_EN.
module tb_addr_fifo_buf;

  localparam int DW = 32;
  localparam int DL = 2;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] addr_fifo_din;
  logic          addr_fifo_wr;
  logic          addr_fifo_rd;
  logic [DW-1:0] addr_fifo_dout;
  logic          addr_fifo_dout_val;
  logic          addr_fifo_full;
  logic          addr_fifo_empty;
  logic          addr_fifo_almost_full;
  logic [15:0]   addr_fifo_threshold;
  logic          addr_fifo_overrun;
  logic          addr_fifo_underrun;
  logic          clr_flags;
  logic [15:0]   words_in_addr_fifo;
`ifdef ADDR_FIFO_HWM_EN
  logic [15:0]   addr_fifo_hwm;
`endif

  addr_fifo_buf #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .addr_fifo_din         (addr_fifo_din),
    .addr_fifo_wr          (addr_fifo_wr),
    .addr_fifo_rd          (addr_fifo_rd),
    .addr_fifo_dout        (addr_fifo_dout),
    .addr_fifo_dout_val    (addr_fifo_dout_val),
    .addr_fifo_full        (addr_fifo_full),
    .addr_fifo_empty       (addr_fifo_empty),
    .addr_fifo_almost_full (addr_fifo_almost_full),
    .addr_fifo_threshold   (addr_fifo_threshold),
    .addr_fifo_overrun     (addr_fifo_overrun),
    .addr_fifo_underrun    (addr_fifo_underrun),
    .clr_flags             (clr_flags),
    .words_in_addr_fifo    (words_in_addr_fifo)
`ifdef ADDR_FIFO_HWM_EN
    ,
    .addr_fifo_hwm         (addr_fifo_hwm)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard / reference state
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout;
  logic          m_dout_val;
  logic          m_over;
  logic          m_under;
  int            m_hwm;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout     = '0;
    m_dout_val = 1'b0;
    m_over     = 1'b0;
    m_under    = 1'b0;
    m_hwm      = 0;
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = m_q.size();
    chk({tag, ".dout"},     addr_fifo_dout, m_dout);
    chk({tag, ".dout_val"}, 32'(addr_fifo_dout_val), 32'(m_dout_val));
    chk({tag, ".count"},    32'(words_in_addr_fifo), 32'(sz));
    chk({tag, ".full"},     32'(addr_fifo_full), 32'(sz == DEPTH));
    chk({tag, ".empty"},    32'(addr_fifo_empty), 32'(sz == 0));
    chk({tag, ".afull"},    32'(addr_fifo_almost_full),
        32'((addr_fifo_threshold != 16'd0) && (sz >= int'(addr_fifo_threshold))));
    chk({tag, ".overrun"},  32'(addr_fifo_overrun), 32'(m_over));
    chk({tag, ".underrun"}, 32'(addr_fifo_underrun), 32'(m_under));
`ifdef ADDR_FIFO_HWM_EN
    chk({tag, ".hwm"},      32'(addr_fifo_hwm), 32'(m_hwm));
`endif
  endtask

  // One clock: drive, let the edge happen, update the reference, compare.
  task automatic step(input string tag, input logic wr, input logic [DW-1:0] din,
                      input logic rd, input logic clr);
    int  sz;
    bit  rd_acc, wr_acc;
    addr_fifo_wr  = wr;
    addr_fifo_din = din;
    addr_fifo_rd  = rd;
    clr_flags     = clr;
    @(posedge clk);
    #1;
    sz     = m_q.size();
    rd_acc = rd && (sz != 0);
    wr_acc = wr && ((sz != DEPTH) || rd_acc);
    if (rd_acc) m_dout = m_q.pop_front();
    if (wr_acc) m_q.push_back(din);
    m_dout_val = rd_acc;
    m_over  = (wr && !wr_acc) || (m_over && !clr);
    m_under = (rd && !rd_acc) || (m_under && !clr);
    if (clr)                   m_hwm = m_q.size();
    else if (m_q.size() > m_hwm) m_hwm = m_q.size();
    $display("%0t %-10s wr=%0b din=%h rd=%0b clr=%0b -> dout=%h val=%0b cnt=%0d",
             $time, tag, wr, din, rd, clr, addr_fifo_dout, addr_fifo_dout_val,
             words_in_addr_fifo);
    check_all(tag);
    addr_fifo_wr = 1'b0;
    addr_fifo_rd = 1'b0;
    clr_flags    = 1'b0;
  endtask

  initial begin
    reset               = 1'b0;
    addr_fifo_din       = '0;
    addr_fifo_wr        = 1'b0;
    addr_fifo_rd        = 1'b0;
    addr_fifo_threshold = 16'd0;
    clr_flags           = 1'b0;
    model_reset();
    #12;
    check_all("rst");
    @(posedge clk);
    #1 reset = 1'b1;
    check_all("rst_rel");

    // Basic ordered write then read
    for (int i = 0; i < 4; i++) step("wr_basic", 1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("rd_basic", 1'b0, '0, 1'b1, 1'b0);
    step("idle", 1'b0, '0, 1'b0, 1'b0);

    // Fill, overrun with 0xDEAD, clear, drain
    for (int i = 0; i < 4; i++) step("wr_fill", 1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
    step("wr_over", 1'b1, 32'h0000DEAD, 1'b0, 1'b0);
    step("clr_over", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("rd_drain", 1'b0, '0, 1'b1, 1'b0);

    // Underrun paths
    step("rd_empty", 1'b0, '0, 1'b1, 1'b0);
    step("clr_under", 1'b0, '0, 1'b0, 1'b1);
    step("wrrd_empty", 1'b1, 32'h3000, 1'b1, 1'b0);
    step("rd_clr_win", 1'b0, '0, 1'b1, 1'b1);
    step("rd_empty2", 1'b0, '0, 1'b1, 1'b1);
    step("clr_under2", 1'b0, '0, 1'b0, 1'b1);

    // Almost-full threshold
    addr_fifo_threshold = 16'd3;
    for (int i = 0; i < 3; i++) step("wr_thr3", 1'b1, 32'h4000 + 32'(i), 1'b0, 1'b0);
    step("rd_thr3", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step("rd_thr3d", 1'b0, '0, 1'b1, 1'b0);
    addr_fifo_threshold = 16'd0;
    for (int i = 0; i < 4; i++) step("wr_thr0", 1'b1, 32'h4100 + 32'(i), 1'b0, 1'b0);
    addr_fifo_threshold = 16'd9;
    step("thr_big", 1'b0, '0, 1'b0, 1'b0);
    addr_fifo_threshold = 16'd4;
    step("thr_dep", 1'b0, '0, 1'b0, 1'b0);

    // Full with simultaneous write+read across pointer wrap
    for (int i = 0; i < 10; i++) step("wrrd_full", 1'b1, 32'h5000 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("rd_full_d", 1'b0, '0, 1'b1, 1'b0);

    // Mid-stream asynchronous reset with 3 words stored
    step("clr_hwm", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("wr_pre_rst", 1'b1, 32'h6000 + 32'(i), 1'b0, 1'b0);
    step("rd_pre_rst", 1'b0, '0, 1'b1, 1'b0);
    step("wr_pre_rst", 1'b1, 32'h6003, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1 check_all("rst_hold");
    reset = 1'b1;
    step("wr_post", 1'b1, 32'h7000, 1'b0, 1'b0);
    step("rd_post", 1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
